assert_event_monitor: RTL and testbench

Synthesizable pass/fail accumulator that consumes per-cycle check results from an immediate-assertion checker. It gates result collection the way `$assertoff`/`$asserton` gate assertion evaluation: results are collected only while monitoring is on and after a hold-off window, so uninitialised or settling values (X at start-up) are not counted. It provides saturating pass/fail counts, a sticky error flag and a fail-limit halt, and feeds status registers and end-of-test checks.

---
 rtl/assert_event_monitor.sv | 153 +++++++++++++++
 tb/tb_assert_event_monitor.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/assert_event_monitor.sv
// assert_event_monitor: gated pass/fail accumulator for per-cycle check results.
// Results are collected only while monitoring is on and after a hold-off window;
// counters saturate, the first counted fail sets a sticky flag, and reaching the
// fail limit halts collection until clr or rst.
// Optional feature macro: ASSERT_MON_TIMESTAMP_EN adds a free-running cycle
// counter and latches its value at the first counted fail (first_fail_time).
module assert_event_monitor #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned HOLDOFF    = 4,
  parameter int unsigned FAIL_LIMIT = 1,
  parameter int unsigned TS_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mon_on,
  input  logic             clr,
  input  logic             chk_valid,
  input  logic             chk_pass,
  output logic [1:0]       state,
  output logic             active,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err_sticky,
  output logic             halted
`ifdef ASSERT_MON_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]  first_fail_time
`endif
);

  localparam int unsigned HW        = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam int unsigned HOLD_LAST = (HOLDOFF == 0) ? 0 : HOLDOFF - 1;
  localparam int unsigned CW1       = CNT_W + 1;

  typedef enum logic [1:0] {
    S_OFF    = 2'd0,
    S_HOLD   = 2'd1,
    S_ACTIVE = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   hold_cnt, hold_d;
  logic            sample, count_pass, count_fail, lim_hit;
  logic [CW1-1:0]  fail_inc;
  logic [CNT_W-1:0] pass_d, fail_d;
  logic            err_d;

  assign state = state_q;

  // A sample counts only in ACTIVE and is discarded by a same-cycle clear
  assign sample     = (state_q == S_ACTIVE) && chk_valid && !clr;
  assign count_pass = sample && chk_pass;
  assign count_fail = sample && !chk_pass;
  assign fail_inc   = {1'b0, fail_cnt} + CW1'(1);
  assign lim_hit    = count_fail && (FAIL_LIMIT != 0) && (fail_inc >= CW1'(FAIL_LIMIT));

  // State register with registered decodes of the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_OFF;
      hold_cnt <= '0;
      active   <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_cnt <= hold_d;
      active   <= (state_d == S_ACTIVE);
      halted   <= (state_d == S_HALT);
    end
  end

  // Next-state logic: hold-off sequencing, monitor gating, fail-limit halt
  always_comb begin
    state_d = state_q;
    hold_d  = hold_cnt;
    case (state_q)
      S_OFF: begin
        if (mon_on) begin
          hold_d  = '0;
          state_d = (HOLDOFF == 0) ? S_ACTIVE : S_HOLD;
        end
      end
      S_HOLD: begin
        if (!mon_on)                          state_d = S_OFF;
        else if (hold_cnt == HW'(HOLD_LAST))  state_d = S_ACTIVE;
        else                                  hold_d  = hold_cnt + HW'(1);
      end
      S_ACTIVE: begin
        if (lim_hit)      state_d = S_HALT;
        else if (!mon_on) state_d = S_OFF;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_OFF;
    endcase
    if (clr) begin
      state_d = S_OFF;
      hold_d  = '0;
    end
  end

  // Output logic: saturating counter updates and sticky error
  always_comb begin
    pass_d = pass_cnt;
    fail_d = fail_cnt;
    err_d  = err_sticky;
    if (clr) begin
      pass_d = '0;
      fail_d = '0;
      err_d  = 1'b0;
    end else begin
      if (count_pass && (pass_cnt != '1)) pass_d = pass_cnt + CNT_W'(1);
      if (count_fail) begin
        err_d = 1'b1;
        if (fail_cnt != '1) fail_d = fail_cnt + CNT_W'(1);
      end
    end
  end

  // Counter and flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      err_sticky <= 1'b0;
    end else begin
      pass_cnt   <= pass_d;
      fail_cnt   <= fail_d;
      err_sticky <= err_d;
    end
  end

`ifdef ASSERT_MON_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  // Free-running cycle stamp; latched once at the first counted fail
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q            <= '0;
      first_fail_time <= '0;
    end else if (clr) begin
      ts_q            <= '0;
      first_fail_time <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
      if (count_fail && !err_sticky) first_fail_time <= ts_q;
    end
  end
`else
  localparam int unsigned ts_w_unused = TS_W;
`endif

endmodule

// File: tb/tb_assert_event_monitor.sv
// Testbench for assert_event_monitor: directed test-plan steps followed by
// randomized traffic, all compared against a behavioural reference model.
// Two instances: u0 (CNT_W=4, HOLDOFF=4, FAIL_LIMIT=3), u1 (CNT_W=16, HOLDOFF=0, no limit).
module tb_assert_event_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mon_on, clr, chk_valid, chk_pass;

  logic [1:0]  state0, state1;
  logic        active0, active1, err0, err1, halted0, halted1;
  logic [3:0]  pass0, fail0;
  logic [15:0] pass1, fail1;
`ifdef ASSERT_MON_TIMESTAMP_EN
  logic [31:0] fft0, fft1;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state (per instance)
  int          m_state[2];
  int          m_wait[2];
  int          m_pass[2];
  int          m_fail[2];
  bit          m_err[2];
  int unsigned m_ts[2];
  int unsigned m_fft[2];
  int          p_hold[2] = '{4, 0};
  int          p_lim[2]  = '{3, 0};
  int          p_max[2]  = '{15, 65535};
  bit          seq[6]    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  always #5 clk = ~clk;

  assert_event_monitor #(.CNT_W(4), .HOLDOFF(4), .FAIL_LIMIT(3), .TS_W(32)) u0 (
    .clk(clk), .rst(rst), .mon_on(mon_on[0]), .clr(clr[0]),
    .chk_valid(chk_valid[0]), .chk_pass(chk_pass[0]),
    .state(state0), .active(active0), .pass_cnt(pass0), .fail_cnt(fail0),
    .err_sticky(err0), .halted(halted0)
`ifdef ASSERT_MON_TIMESTAMP_EN
    , .first_fail_time(fft0)
`endif
  );

  assert_event_monitor #(.CNT_W(16), .HOLDOFF(0), .FAIL_LIMIT(0), .TS_W(32)) u1 (
    .clk(clk), .rst(rst), .mon_on(mon_on[1]), .clr(clr[1]),
    .chk_valid(chk_valid[1]), .chk_pass(chk_pass[1]),
    .state(state1), .active(active1), .pass_cnt(pass1), .fail_cnt(fail1),
    .err_sticky(err1), .halted(halted1)
`ifdef ASSERT_MON_TIMESTAMP_EN
    , .first_fail_time(fft1)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0; m_wait[i] = 0; m_pass[i] = 0; m_fail[i] = 0;
      m_err[i] = 1'b0; m_ts[i] = 0; m_fft[i] = 0;
    end
  endtask

  // One clock edge of the behavioural rules for instance i
  task automatic model_step(input int i);
    bit lim;
    lim = 1'b0;
    if (clr[i]) begin
      m_pass[i] = 0; m_fail[i] = 0; m_err[i] = 1'b0;
      m_fft[i] = 0; m_ts[i] = 0; m_state[i] = 0;
      return;
    end
    if (m_state[i] == 2 && chk_valid[i]) begin
      if (chk_pass[i]) begin
        m_pass[i] = (m_pass[i] + 1 > p_max[i]) ? p_max[i] : m_pass[i] + 1;
      end else begin
        if (p_lim[i] != 0 && m_fail[i] + 1 >= p_lim[i]) lim = 1'b1;
        m_fail[i] = (m_fail[i] + 1 > p_max[i]) ? p_max[i] : m_fail[i] + 1;
        if (!m_err[i]) m_fft[i] = m_ts[i];
        m_err[i] = 1'b1;
      end
    end
    case (m_state[i])
      0: if (mon_on[i]) begin
           m_state[i] = (p_hold[i] == 0) ? 2 : 1;
           m_wait[i]  = p_hold[i];
         end
      1: if (!mon_on[i])          m_state[i] = 0;
         else if (m_wait[i] == 1) m_state[i] = 2;
         else                     m_wait[i]--;
      2: if (lim)                 m_state[i] = 3;
         else if (!mon_on[i])     m_state[i] = 0;
      default: ;
    endcase
    m_ts[i]++;
  endtask

  task automatic check_all();
    check("u0.state",  64'(state0),  64'(m_state[0]));
    check("u0.active", 64'(active0), 64'(m_state[0] == 2));
    check("u0.halted", 64'(halted0), 64'(m_state[0] == 3));
    check("u0.pass",   64'(pass0),   64'(m_pass[0]));
    check("u0.fail",   64'(fail0),   64'(m_fail[0]));
    check("u0.err",    64'(err0),    64'(m_err[0]));
    check("u1.state",  64'(state1),  64'(m_state[1]));
    check("u1.active", 64'(active1), 64'(m_state[1] == 2));
    check("u1.halted", 64'(halted1), 64'(m_state[1] == 3));
    check("u1.pass",   64'(pass1),   64'(m_pass[1]));
    check("u1.fail",   64'(fail1),   64'(m_fail[1]));
    check("u1.err",    64'(err1),    64'(m_err[1]));
`ifdef ASSERT_MON_TIMESTAMP_EN
    check("u0.fft",    64'(fft0),    64'(m_fft[0]));
    check("u1.fft",    64'(fft1),    64'(m_fft[1]));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; mon_on = '0; clr = '0; chk_valid = '0; chk_pass = '0;
    model_reset();
    #12;
    check_all();
    @(posedge clk); #1;
    check_all();
    rst = 1'b0;

    // Start-up masking on u0, timestamp scenario on u1
    mon_on = 2'b11;
    for (int e = 0; e < 25; e++) begin
      chk_valid[0] = (e < 15);
      chk_pass[0]  = (e >= 5);
      chk_valid[1] = 1'b1;
      chk_pass[1]  = !(e == 12 || e == 20);
      tick();
    end
    chk_valid = '0;
    check("startup.pass", 64'(pass0), 64'd10);
    check("startup.fail", 64'(fail0), 64'd0);
    check("startup.err",  64'(err0),  64'd0);
    check("ts.fail",      64'(fail1), 64'd2);
    check("ts.pass",      64'(pass1), 64'd22);
`ifdef ASSERT_MON_TIMESTAMP_EN
    check("ts.first",     64'(fft1),  64'd12);
`endif
    clr[1] = 1'b1;
    tick();
    clr[1] = 1'b0;
    check("ts.clr.state", 64'(state1), 64'd0);
    check("ts.clr.fail",  64'(fail1),  64'd0);
`ifdef ASSERT_MON_TIMESTAMP_EN
    check("ts.clr.first", 64'(fft1),   64'd0);
`endif

    // Hold-off abort on u0
    clr[0] = 1'b1; mon_on[0] = 1'b0;
    tick();
    clr[0] = 1'b0;
    mon_on[0] = 1'b1; chk_valid[0] = 1'b1; chk_pass[0] = 1'b1;
    tick();
    check("abort.hold", 64'(state0), 64'd1);
    tick();
    mon_on[0] = 1'b0;
    tick();
    check("abort.state", 64'(state0), 64'd0);
    check("abort.pass",  64'(pass0),  64'd0);
    chk_valid[0] = 1'b0;
    mon_on[0] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("rehold.state", 64'(state0), (k < 5) ? 64'd1 : 64'd2);
    end

    // Fail limit: pass,fail,fail,pass,fail,fail
    chk_valid[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk_pass[0] = seq[k];
      tick();
      if (k == 4) begin
        check("limit.fail",   64'(fail0),   64'd3);
        check("limit.halted", 64'(halted0), 64'd1);
        check("limit.pass",   64'(pass0),   64'd2);
      end
    end
    check("limit.drop", 64'(fail0), 64'd3);
    chk_valid[0] = 1'b0;
    mon_on[0] = 1'b0;
    tick(); tick();
    mon_on[0] = 1'b1;
    tick();
    check("limit.keep", 64'(state0), 64'd3);
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    check("limit.clr.state", 64'(state0), 64'd0);
    check("limit.clr.fail",  64'(fail0),  64'd0);
    check("limit.clr.pass",  64'(pass0),  64'd0);
    check("limit.clr.err",   64'(err0),   64'd0);

    // Saturation: 20 passes into a 4-bit counter
    repeat (5) tick();
    chk_valid[0] = 1'b1; chk_pass[0] = 1'b1;
    repeat (20) tick();
    chk_valid[0] = 1'b0;
    check("sat.pass", 64'(pass0), 64'd15);

    // Reset mid-operation with pass_cnt=7
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    repeat (5) tick();
    chk_valid[0] = 1'b1;
    repeat (7) tick();
    chk_valid[0] = 1'b0;
    check("rstmid.pre", 64'(pass0), 64'd7);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check("rstmid.pass",  64'(pass0),  64'd0);
    check("rstmid.state", 64'(state0), 64'd0);
    check_all();
    @(posedge clk); #1;
    check_all();
    mon_on = '0;
    rst = 1'b0;
    tick();
    check("rstmid.off", 64'(state0), 64'd0);

    // Randomized traffic on both instances
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        mon_on[i]    = ($urandom_range(0, 9) != 0);
        clr[i]       = ($urandom_range(0, 29) == 0);
        chk_valid[i] = ($urandom_range(0, 3) != 0);
        chk_pass[i]  = ($urandom_range(0, 2) != 0);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
